// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoder-side inputs plus registered EX-side outputs and hazard controls.
// master = upstream ID/hazard consumer, slave = the id_ex_stage register itself.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) ();
    logic [15:0]       ctrl_i;
    logic [DATA_W-1:0] pc_plus4_i;
    logic [DATA_W-1:0] rs_data_i;
    logic [DATA_W-1:0] rt_data_i;
    logic [DATA_W-1:0] imm_i;
    logic [REG_AW-1:0] rs_addr_i;
    logic [REG_AW-1:0] rt_addr_i;
    logic [REG_AW-1:0] rd_addr_i;
    logic              id_valid_i;
    logic              flush_i;

    logic [15:0]       ctrl_o;
    logic [DATA_W-1:0] pc_plus4_o;
    logic [DATA_W-1:0] rs_data_o;
    logic [DATA_W-1:0] rt_data_o;
    logic [DATA_W-1:0] imm_o;
    logic [REG_AW-1:0] rs_addr_o;
    logic [REG_AW-1:0] rt_addr_o;
    logic [REG_AW-1:0] rd_addr_o;
    logic              valid_o;
    logic              stall_o;
    logic              pc_write_o;
    logic              ifid_write_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport master (
        output ctrl_i, pc_plus4_i, rs_data_i, rt_data_i, imm_i,
               rs_addr_i, rt_addr_i, rd_addr_i, id_valid_i, flush_i,
        input  ctrl_o, pc_plus4_o, rs_data_o, rt_data_o, imm_o,
               rs_addr_o, rt_addr_o, rd_addr_o, valid_o,
               stall_o, pc_write_o, ifid_write_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  ctrl_i, pc_plus4_i, rs_data_i, rt_data_i, imm_i,
               rs_addr_i, rt_addr_i, rd_addr_i, id_valid_i, flush_i,
        output ctrl_o, pc_plus4_o, rs_data_o, rt_data_o, imm_o,
               rs_addr_o, rt_addr_o, rd_addr_o, valid_o,
               stall_o, pc_write_o, ifid_write_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and saturating event counters.
// Latency: 1 cycle from ID inputs to EX outputs; stall/pc_write/ifid_write are combinational.
// Backpressure: a load-use hazard holds PC and IF/ID for one cycle while a bubble enters EX.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic          clk_i,
    input logic          rst_i,
    id_ex_stage_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [15:0]       ctrl_q;
    logic [DATA_W-1:0] pc_plus4_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;
    logic [REG_AW-1:0] rs_addr_q;
    logic [REG_AW-1:0] rt_addr_q;
    logic [REG_AW-1:0] rd_addr_q;
    logic              valid_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    logic hz;
    logic stall;
    logic bubble;

    // ctrl bit 3 is MemRead; the rt match is deliberately checked for every opcode.
    assign hz = valid_q & ctrl_q[3] & (rt_addr_q != '0) & bus.id_valid_i &
                ((rt_addr_q == bus.rs_addr_i) | (rt_addr_q == bus.rt_addr_i));
    assign stall  = hz & ~bus.flush_i;
    assign bubble = bus.flush_i | stall;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_q     <= '0;
            pc_plus4_q <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            rs_addr_q  <= '0;
            rt_addr_q  <= '0;
            rd_addr_q  <= '0;
            valid_q    <= 1'b0;
        end else if (bubble) begin
            ctrl_q     <= '0;
            pc_plus4_q <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            rs_addr_q  <= '0;
            rt_addr_q  <= '0;
            rd_addr_q  <= '0;
            valid_q    <= 1'b0;
        end else begin
            // An empty ID slot still carries its data, but never its side effects.
            ctrl_q     <= bus.id_valid_i ? bus.ctrl_i : 16'h0000;
            pc_plus4_q <= bus.pc_plus4_i;
            rs_data_q  <= bus.rs_data_i;
            rt_data_q  <= bus.rt_data_i;
            imm_q      <= bus.imm_i;
            rs_addr_q  <= bus.rs_addr_i;
            rt_addr_q  <= bus.rt_addr_i;
            rd_addr_q  <= bus.rd_addr_i;
            valid_q    <= bus.id_valid_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (bus.flush_i && flush_cnt_q != CNT_MAX)
                flush_cnt_q <= flush_cnt_q + 1'b1;
            if (stall && stall_cnt_q != CNT_MAX)
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign bus.ctrl_o       = ctrl_q;
    assign bus.pc_plus4_o   = pc_plus4_q;
    assign bus.rs_data_o    = rs_data_q;
    assign bus.rt_data_o    = rt_data_q;
    assign bus.imm_o        = imm_q;
    assign bus.rs_addr_o    = rs_addr_q;
    assign bus.rt_addr_o    = rt_addr_q;
    assign bus.rd_addr_o    = rd_addr_q;
    assign bus.valid_o      = valid_q;
    assign bus.stall_o      = stall;
    assign bus.pc_write_o   = ~stall;
    assign bus.ifid_write_o = ~stall;
    assign bus.stall_cnt_o  = stall_cnt_q;
    assign bus.flush_cnt_o  = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, async reset mid-stall, then random traffic vs a model.
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;
    localparam logic [15:0] ADDI = 16'h8C00;
    localparam logic [15:0] LW   = 16'h8C09;
    localparam logic [15:0] ADD  = 16'h8000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) m_if ();
    id_ex_stage_if #(.DATA_W(DW), .REG_AW(AW), .CNT_W(2))  s_if ();

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_n), .bus(m_if.slave));
    id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst_n), .bus(s_if.slave));

    assign s_if.ctrl_i     = m_if.ctrl_i;
    assign s_if.pc_plus4_i = m_if.pc_plus4_i;
    assign s_if.rs_data_i  = m_if.rs_data_i;
    assign s_if.rt_data_i  = m_if.rt_data_i;
    assign s_if.imm_i      = m_if.imm_i;
    assign s_if.rs_addr_i  = m_if.rs_addr_i;
    assign s_if.rt_addr_i  = m_if.rt_addr_i;
    assign s_if.rd_addr_i  = m_if.rd_addr_i;
    assign s_if.id_valid_i = m_if.id_valid_i;
    assign s_if.flush_i    = m_if.flush_i;

    typedef struct {
        logic [15:0] ctrl;
        logic [31:0] pc, rs, rt, imm;
        logic [4:0]  rsa, rta, rda;
        logic        vld;
    } ex_t;

    typedef struct {
        logic [15:0] ctrl;
        logic [4:0]  rsa, rta, rda;
        logic        idv, fl;
        logic        exp_stall;
        logic [15:0] exp_ctrl;
        logic        exp_vld;
    } vec_t;

    ex_t  mdl;
    int   m_stall_cnt;
    int   m_flush_cnt;
    int   n_vec;
    int   n_err;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] c, input int rsa, input int rta, input int rda,
                                input logic idv, input logic fl, input logic es,
                                input logic [15:0] ec, input logic ev);
        vec_t v;
        v.ctrl = c; v.rsa = 5'(rsa); v.rta = 5'(rta); v.rda = 5'(rda);
        v.idv = idv; v.fl = fl; v.exp_stall = es; v.exp_ctrl = ec; v.exp_vld = ev;
        return v;
    endfunction

    function automatic void model_reset();
        mdl.ctrl = '0; mdl.pc = '0; mdl.rs = '0; mdl.rt = '0; mdl.imm = '0;
        mdl.rsa = '0; mdl.rta = '0; mdl.rda = '0; mdl.vld = 1'b0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endfunction

    // A loaded value in EX conflicts with an ID source register; flush cancels the need.
    function automatic logic model_stall();
        logic ex_is_load = mdl.vld && mdl.ctrl[3] && mdl.rta != 0;
        logic uses = (m_if.rs_addr_i == mdl.rta) || (m_if.rt_addr_i == mdl.rta);
        return ex_is_load && m_if.id_valid_i && uses && !m_if.flush_i;
    endfunction

    function automatic void model_edge();
        logic st = model_stall();
        if (m_if.flush_i || st) begin
            if (m_if.flush_i) m_flush_cnt = (m_flush_cnt < 65535) ? m_flush_cnt + 1 : m_flush_cnt;
            else              m_stall_cnt = (m_stall_cnt < 65535) ? m_stall_cnt + 1 : m_stall_cnt;
            mdl.ctrl = '0; mdl.pc = '0; mdl.rs = '0; mdl.rt = '0; mdl.imm = '0;
            mdl.rsa = '0; mdl.rta = '0; mdl.rda = '0; mdl.vld = 1'b0;
        end else begin
            mdl.ctrl = m_if.id_valid_i ? m_if.ctrl_i : 16'h0;
            mdl.pc = m_if.pc_plus4_i; mdl.rs = m_if.rs_data_i;
            mdl.rt = m_if.rt_data_i;  mdl.imm = m_if.imm_i;
            mdl.rsa = m_if.rs_addr_i; mdl.rta = m_if.rt_addr_i; mdl.rda = m_if.rd_addr_i;
            mdl.vld = m_if.id_valid_i;
        end
    endfunction

    task automatic check_comb();
        logic es = model_stall();
        chk("stall_o", 32'(m_if.stall_o), 32'(es));
        chk("pc_write_o", 32'(m_if.pc_write_o), 32'(!es));
        chk("ifid_write_o", 32'(m_if.ifid_write_o), 32'(!es));
    endtask

    task automatic check_regs();
        chk("ctrl_o", 32'(m_if.ctrl_o), 32'(mdl.ctrl));
        chk("valid_o", 32'(m_if.valid_o), 32'(mdl.vld));
        chk("pc_plus4_o", m_if.pc_plus4_o, mdl.pc);
        chk("rs_data_o", m_if.rs_data_o, mdl.rs);
        chk("rt_data_o", m_if.rt_data_o, mdl.rt);
        chk("imm_o", m_if.imm_o, mdl.imm);
        chk("rs_addr_o", 32'(m_if.rs_addr_o), 32'(mdl.rsa));
        chk("rt_addr_o", 32'(m_if.rt_addr_o), 32'(mdl.rta));
        chk("rd_addr_o", 32'(m_if.rd_addr_o), 32'(mdl.rda));
        chk("stall_cnt_o", 32'(m_if.stall_cnt_o), 32'(m_stall_cnt));
        chk("flush_cnt_o", 32'(m_if.flush_cnt_o), 32'(m_flush_cnt));
        chk("sat_stall_cnt", 32'(s_if.stall_cnt_o), 32'((m_stall_cnt > 3) ? 3 : m_stall_cnt));
        chk("sat_flush_cnt", 32'(s_if.flush_cnt_o), 32'((m_flush_cnt > 3) ? 3 : m_flush_cnt));
    endtask

    task automatic drive(input logic [15:0] c, input logic [4:0] rsa, input logic [4:0] rta,
                         input logic [4:0] rda, input logic idv, input logic fl);
        m_if.ctrl_i = c;
        m_if.rs_addr_i = rsa; m_if.rt_addr_i = rta; m_if.rd_addr_i = rda;
        m_if.id_valid_i = idv; m_if.flush_i = fl;
        m_if.pc_plus4_i = $urandom; m_if.rs_data_i = $urandom;
        m_if.rt_data_i = $urandom;  m_if.imm_i = $urandom;
    endtask

    task automatic do_edge();
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();

        // Reset with busy-looking inputs: everything must read zero and upstream may advance.
        drive(LW, 5'd3, 5'd3, 5'd7, 1'b1, 1'b0);
        #1 rst_n = 1'b0;
        #3;
        check_regs();
        check_comb();
        @(negedge clk);
        rst_n = 1'b1;

        tbl.push_back(mk(ADDI, 1, 2, 0, 1, 0, 0, ADDI, 1));
        tbl.push_back(mk(LW,   1, 8, 0, 1, 0, 0, LW,   1));
        tbl.push_back(mk(ADD,  8, 3, 4, 1, 0, 1, 16'h0, 0));
        tbl.push_back(mk(ADD,  8, 3, 4, 1, 0, 0, ADD,  1));
        tbl.push_back(mk(LW,   0, 0, 0, 1, 0, 0, LW,   1));
        tbl.push_back(mk(ADD,  0, 0, 4, 1, 0, 0, ADD,  1));
        tbl.push_back(mk(LW,   1, 8, 0, 1, 0, 0, LW,   1));
        tbl.push_back(mk(ADD,  9, 10, 4, 1, 0, 0, ADD, 1));
        tbl.push_back(mk(LW,   1, 8, 0, 1, 0, 0, LW,   1));
        tbl.push_back(mk(ADD,  8, 3, 4, 1, 1, 0, 16'h0, 0));
        tbl.push_back(mk(LW,   2, 5, 0, 1, 0, 0, LW,   1));
        tbl.push_back(mk(LW,   5, 5, 0, 1, 0, 1, 16'h0, 0));
        tbl.push_back(mk(LW,   5, 5, 0, 1, 0, 0, LW,   1));
        tbl.push_back(mk(LW,   5, 6, 0, 1, 0, 1, 16'h0, 0));
        tbl.push_back(mk(LW,   5, 6, 0, 1, 0, 0, LW,   1));
        tbl.push_back(mk(LW,   6, 7, 0, 1, 0, 1, 16'h0, 0));
        tbl.push_back(mk(LW,   6, 7, 0, 1, 0, 0, LW,   1));
        tbl.push_back(mk(ADD,  7, 7, 4, 0, 0, 0, 16'h0, 0));
        tbl.push_back(mk(LW,   1, 9, 0, 1, 0, 0, LW,   1));
        tbl.push_back(mk(ADD,  9, 1, 4, 1, 0, 1, 16'h0, 0));
        tbl.push_back(mk(ADD,  9, 1, 4, 1, 0, 0, ADD,  1));

        foreach (tbl[i]) begin
            drive(tbl[i].ctrl, tbl[i].rsa, tbl[i].rta, tbl[i].rda, tbl[i].idv, tbl[i].fl);
            #1;
            chk("tbl_stall", 32'(m_if.stall_o), 32'(tbl[i].exp_stall));
            check_comb();
            do_edge();
            chk("tbl_ctrl", 32'(m_if.ctrl_o), 32'(tbl[i].exp_ctrl));
            chk("tbl_valid", 32'(m_if.valid_o), 32'(tbl[i].exp_vld));
        end
        chk("tbl_stall_total", 32'(m_if.stall_cnt_o), 32'd5);
        chk("tbl_flush_total", 32'(m_if.flush_cnt_o), 32'd1);
        chk("tbl_stall_saturated", 32'(s_if.stall_cnt_o), 32'd3);

        // Async reset while a stall is being requested, released before the next edge.
        drive(LW, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0);
        #1 check_comb();
        do_edge();
        drive(ADD, 5'd8, 5'd2, 5'd4, 1'b1, 1'b0);
        #1;
        chk("mid_stall_pre", 32'(m_if.stall_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_stall_drop", 32'(m_if.stall_o), 32'd0);
        chk("mid_stall_pcw", 32'(m_if.pc_write_o), 32'd1);
        check_regs();
        rst_n = 1'b1;
        do_edge();
        chk("held_add_loaded", 32'(m_if.ctrl_o), 32'(ADD));

        for (int n = 0; n < 400; n++) begin
            logic [15:0] c;
            c = 16'($urandom);
            c[3] = ($urandom_range(0, 1) == 1);
            drive(c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0));
            #1 check_comb();
            do_edge();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
